// File: rtl/imem_fetch.sv
// Synchronous-read instruction memory with a fetch handshake, 1- or 2-cycle read
// latency, alignment/range fault reporting and a program-load write port.
module imem_fetch #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 256,
  parameter int              READ_LAT  = 1,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter logic [31:0]     NOP_INSN  = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          PC_out,
  input  logic                     fetch_req,
  output logic                     fetch_ready,
  output logic [31:0]              inst_out,
  output logic                     inst_valid,
  output logic                     inst_fault,
  output logic [1:0]               fault_code,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(4 * DEPTH);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_ALIGN = 2'b01;
  localparam logic [1:0] CODE_RANGE = 2'b10;

  // Handshake: a fetch is accepted at a rising edge where fetch_req & fetch_ready;
  // the requester holds fetch_req/PC_out until then. Each acceptance yields exactly
  // one inst_valid pulse READ_LAT cycles later, in order, with no backpressure.

  logic [31:0]     mem [DEPTH];
  logic            ready_q;
  logic [XLEN-1:0] offset;
  logic            misaligned;
  logic            out_of_range;
  logic [1:0]      code;
  logic [AW-1:0]   idx;
  logic            accept;

  logic            s1_valid;
  logic            s1_fault;
  logic [1:0]      s1_code;
  logic [31:0]     s1_data;

  assign offset       = PC_out - BASE_ADDR;
  assign misaligned   = |PC_out[1:0];
  assign out_of_range = (PC_out < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign code         = misaligned   ? CODE_ALIGN :
                        out_of_range ? CODE_RANGE : CODE_NONE;
  assign idx          = offset[AW+1:2];

  assign fetch_ready  = ready_q & ~load_en;
  assign accept       = fetch_req & fetch_ready;

  // Array is deliberately not reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      s1_valid <= 1'b0;
      s1_fault <= 1'b0;
      s1_code  <= CODE_NONE;
      s1_data  <= NOP_INSN;
    end else begin
      ready_q  <= 1'b1;
      s1_valid <= accept;
      s1_fault <= accept && (code != CODE_NONE);
      s1_code  <= accept ? code : CODE_NONE;
      if (accept) begin
        s1_data <= (code != CODE_NONE) ? NOP_INSN : mem[idx];
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        s2_valid;
      logic        s2_fault;
      logic [1:0]  s2_code;
      logic [31:0] s2_data;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s2_valid <= 1'b0;
          s2_fault <= 1'b0;
          s2_code  <= CODE_NONE;
          s2_data  <= NOP_INSN;
        end else begin
          s2_valid <= s1_valid;
          s2_fault <= s1_fault;
          s2_code  <= s1_code;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign inst_valid = s2_valid;
      assign inst_fault = s2_fault;
      assign fault_code = s2_code;
      assign inst_out   = s2_data;
    end else begin : g_lat1
      assign inst_valid = s1_valid;
      assign inst_fault = s1_fault;
      assign fault_code = s1_code;
      assign inst_out   = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: a READ_LAT=1 and a READ_LAT=2 instance share
// all inputs so the same stimulus checks both latencies.
module tb_imem_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        ready1, valid1, fault1;
  logic [1:0]  code1;
  logic [31:0] inst1;
  logic        ready2, valid2, fault2;
  logic [1:0]  code2;
  logic [31:0] inst2;

  int checks = 0;
  int errors = 0;

  imem_fetch #(.READ_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .PC_out(pc), .fetch_req(fetch_req),
    .fetch_ready(ready1), .inst_out(inst1), .inst_valid(valid1),
    .inst_fault(fault1), .fault_code(code1), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  imem_fetch #(.READ_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .PC_out(pc), .fetch_req(fetch_req),
    .fetch_ready(ready2), .inst_out(inst2), .inst_valid(valid2),
    .inst_fault(fault2), .fault_code(code2), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        fault;
    logic [1:0]  code;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic chk_l1(input string tag, input vec_t v);
    chk({tag, "_l1_valid"}, 32'(valid1), 32'(v.valid));
    chk({tag, "_l1_fault"}, 32'(fault1), 32'(v.fault));
    chk({tag, "_l1_code"},  32'(code1),  32'(v.code));
    chk({tag, "_l1_inst"},  inst1,       v.inst);
  endtask

  task automatic chk_l2(input string tag, input vec_t v);
    chk({tag, "_l2_valid"}, 32'(valid2), 32'(v.valid));
    chk({tag, "_l2_fault"}, 32'(fault2), 32'(v.fault));
    chk({tag, "_l2_code"},  32'(code2),  32'(v.code));
    chk({tag, "_l2_inst"},  inst2,       v.inst);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b1, 1'b0, 2'b00, 32'h0050_0093};
    vecs[1] = '{32'h0000_0004, 1'b1, 1'b0, 2'b00, 32'h00A0_0113};
    vecs[2] = '{32'h0000_0008, 1'b1, 1'b0, 2'b00, 32'h0020_81B3};
    vecs[3] = '{32'h0000_0002, 1'b1, 1'b1, 2'b01, NOP};
    vecs[4] = '{32'h0000_0400, 1'b1, 1'b1, 2'b10, NOP};
    vecs[5] = '{32'h0000_0401, 1'b1, 1'b1, 2'b01, NOP};
    vecs[6] = '{32'hFFFF_FFFC, 1'b1, 1'b1, 2'b10, NOP};
    vecs[7] = '{32'h0000_03FC, 1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF};

    rst       = 1'b0;
    fetch_req = 1'b1;
    pc        = 32'h0;
    load_en   = 1'b0;
    load_addr = 8'h0;
    load_data = 32'h0;

    // Reset held with a pending request.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_l1_valid", 32'(valid1), 32'd0);
      chk("rst_l1_inst",  inst1, NOP);
      chk("rst_l1_ready", 32'(ready1), 32'd0);
      chk("rst_l2_valid", 32'(valid2), 32'd0);
      chk("rst_l2_inst",  inst2, NOP);
    end
    fetch_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(ready1), 32'd0);
    tick();
    chk("rel_l1_ready", 32'(ready1), 32'd1);
    chk("rel_l2_ready", 32'(ready2), 32'd1);

    load_word(8'd0,   32'h0050_0093);
    load_word(8'd1,   32'h00A0_0113);
    load_word(8'd2,   32'h0020_81B3);
    load_word(8'd255, 32'hDEAD_BEEF);

    // Back-to-back fetches: L1 answers in the same step, L2 one step later.
    for (int i = 0; i < 8; i++) begin
      fetch_req = 1'b1;
      pc = vecs[i].pc;
      tick();
      chk_l1($sformatf("vec%0d", i), vecs[i]);
      if (i > 0) chk_l2($sformatf("vec%0d", i - 1), vecs[i - 1]);
      else       chk("vec0_l2_not_yet", 32'(valid2), 32'd0);
    end
    fetch_req = 1'b0;
    tick();
    chk("idle_l1_valid", 32'(valid1), 32'd0);
    chk("idle_l1_hold",  inst1, 32'hDEAD_BEEF);
    chk("idle_l1_fault", 32'(fault1), 32'd0);
    chk("idle_l1_code",  32'(code1), 32'd0);
    chk_l2("vec7", vecs[7]);
    tick();
    chk("idle_l2_valid", 32'(valid2), 32'd0);
    chk("idle_l2_hold",  inst2, 32'hDEAD_BEEF);

    // Load has priority over a simultaneous fetch.
    load_en   = 1'b1;
    load_addr = 8'd10;
    load_data = 32'hCAFE_0001;
    fetch_req = 1'b1;
    pc        = 32'h0000_0004;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("prio_ready", 32'(ready1), 32'd0);
      tick();
      chk("prio_l1_valid", 32'(valid1), 32'd0);
      chk("prio_l2_valid", 32'(valid2), 32'd0);
    end
    load_en = 1'b0;
    #1;
    chk("prio_ready_back", 32'(ready1), 32'd1);
    tick();
    chk("prio_l1_valid_after", 32'(valid1), 32'd1);
    chk("prio_l1_inst_after",  inst1, 32'h00A0_0113);
    pc = 32'h0000_0028;
    tick();
    chk("prio_l2_inst_after", inst2, 32'h00A0_0113);
    chk("load10_l1_inst", inst1, 32'hCAFE_0001);
    fetch_req = 1'b0;
    tick();
    chk("load10_l2_inst", inst2, 32'hCAFE_0001);

    // A load to the same word after acceptance must not disturb the in-flight read.
    fetch_req = 1'b1;
    pc = 32'h0;
    tick();
    chk("inflight_l1_inst", inst1, 32'h0050_0093);
    fetch_req = 1'b0;
    load_en   = 1'b1;
    load_addr = 8'd0;
    load_data = 32'h1111_1111;
    tick();
    load_en = 1'b0;
    chk("inflight_l2_valid", 32'(valid2), 32'd1);
    chk("inflight_l2_inst",  inst2, 32'h0050_0093);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("reload_l1_inst", inst1, 32'h1111_1111);
    tick();
    chk("reload_l2_inst", inst2, 32'h1111_1111);
    tick();

    // Reset while a READ_LAT=2 result is still in flight.
    fetch_req = 1'b1;
    pc = 32'h0000_0004;
    tick();
    fetch_req = 1'b0;
    chk("mid_l2_pending", 32'(valid2), 32'd0);
    rst = 1'b0;
    #2;
    chk("mid_l2_rst_valid", 32'(valid2), 32'd0);
    chk("mid_l2_rst_inst",  inst2, NOP);
    tick();
    chk("mid_l2_after_edge", 32'(valid2), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_l2_post_rst", 32'(valid2), 32'd0);
    chk("mid_ready",       32'(ready2), 32'd1);
    fetch_req = 1'b1;
    pc = 32'h0000_0008;
    tick();
    chk("keep_l1_w2", inst1, 32'h0020_81B3);
    pc = 32'h0000_03FC;
    tick();
    fetch_req = 1'b0;
    chk("keep_l1_w255", inst1, 32'hDEAD_BEEF);
    chk("keep_l2_w2",   inst2, 32'h0020_81B3);
    tick();
    chk("keep_l2_w255", inst2, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, synchronous-read instruction memory with a fetch handshake, configurable read latency, fault reporting and a program-load write port. It sits between the PC register and the decoder in the single-cycle/multi-cycle RV32I core. It replaces the fixed, unhandshaked instruction ROM; the load port lets the bench or boot logic write instructions without a rebuild.

## Interface
- XLEN, 32: fetch address width
- DEPTH, 256: memory depth in 32-bit words; must be a power of two, ≥ 4
- READ_LAT, 1: cycles from fetch acceptance to `inst_valid`; legal values 1 or 2
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned
- NOP_INSN, 32'h0000_0013: value driven on `inst_out` at reset and on faults (`addi x0,x0,0`)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- PC_out  in  XLEN  byte address of the requested instruction
- fetch_req  in  1  fetch request; accepted when `fetch_req & fetch_ready`
- fetch_ready  out  1  block can accept a fetch this cycle
- inst_out  out  32  fetched instruction
- inst_valid  out  1  one-cycle pulse per accepted fetch
- inst_fault  out  1  qualifies `inst_valid`: the fetch faulted
- fault_code  out  2  00 none, 01 misaligned, 10 out of range
- load_en  in  1  write `load_data` to word `load_addr` at this edge
- load_addr  in  $clog2(DEPTH)  word index for loads
- load_data  in  32  instruction word to write

## Operation
- Word index = (PC_out − BASE_ADDR) >> 2, truncated to $clog2(DEPTH) bits after the range check.
- Misaligned: PC_out[1:0] ≠ 0. Out of range: PC_out < BASE_ADDR or PC_out − BASE_ADDR ≥ 4·DEPTH. If both apply, report misaligned (01).
- Faulted fetch: `inst_out` = NOP_INSN, `inst_fault` = 1, array not read.
- `fetch_ready` = `ready_q & ~load_en`; `ready_q` clears on reset and sets at the first clk edge after reset deasserts.
- Load has priority: while `load_en` = 1, no fetch is accepted. The write occurs at the rising edge.
- Array is read at the acceptance edge. With READ_LAT = 2, the result passes through one extra pipeline register. A load to the same word after acceptance does not change the in-flight result.
- Fully pipelined: one acceptance per cycle. Results return in order, one per cycle.
- When `inst_valid` = 0, `inst_out` holds its last value. `inst_fault` and `fault_code` are 0.
- The memory array is not reset; contents survive reset.

## Timing
- Reset (rst = 0, asynchronous):
  - `inst_out` = NOP_INSN; `inst_valid` = 0; `inst_fault` = 0; `fault_code` = 00; `fetch_ready` = 0.
  - All in-flight pipeline stages are cleared; no `inst_valid` is produced for fetches accepted before reset.
- First rising edge with rst = 1 sets `ready_q`; `fetch_ready` = 1 from the next cycle, provided `load_en` = 0.
- Latency: a fetch accepted at edge N gives `inst_valid` high for the cycle after edge N+READ_LAT−1. READ_LAT = 1: visible right after the accepting edge. READ_LAT = 2: one cycle later.
- `fetch_req` without `fetch_ready` is ignored, not queued; the requester holds `fetch_req` and `PC_out`.
- `load_en` rising with `fetch_req` in the same cycle: load wins, fetch not accepted.
- Address wrap: PC_out = BASE_ADDR + 4·DEPTH − 4 is the last legal word; +4 gives fault 10.

## Test plan
- Reset release: hold rst = 0 for 3 cycles with `fetch_req` = 1 → `inst_valid` = 0, `inst_out` = 32'h0000_0013, `fetch_ready` = 0. It rises one cycle after rst = 1.
- Load then fetch (READ_LAT = 1):
  - Stimulus: load words 0..2 = 32'h00500093, 32'h00A00113, 32'h002081B3; then fetch PC_out = 0, 4, 8 back-to-back.
  - Response: three consecutive `inst_valid` pulses with those values in order, `fault_code` = 00.
- Faults:
  - PC_out = 32'h0000_0002 → `inst_fault` = 1, `fault_code` = 01, `inst_out` = 32'h0000_0013.
  - PC_out = 32'h0000_0400 (DEPTH = 256) → code 10.
  - PC_out = 32'h0000_0401 → code 01.
- READ_LAT = 2 pipelining: fetch 0, 4, 8 on consecutive cycles → valids on three consecutive cycles starting two cycles after the first acceptance. A load to word 0 in the cycle after acceptance does not alter the first result.
- Load priority: `load_en` = 1 with `fetch_req` = 1 for 2 cycles → `fetch_ready` = 0, no `inst_valid`. The fetch is accepted in the cycle after `load_en` drops.
- Reset mid-flight (READ_LAT = 2): accept a fetch, assert rst = 0 before its result returns → no `inst_valid` ever for it. Previously loaded words read back intact after reset.
